vec_mem_sequencer: RTL and testbench
====================================

Name: vec_mem_sequencer

Overview:
- Sits in the MEM stage, between the EX/MEM pipeline register and the data RAM.
- Turns one scalar or vector load/store into a sequence of single-element (16-bit) RAM accesses. A vector access covers 16 consecutive addresses.
- For loads, it gathers the returned elements into a 16-lane vector. For all accesses, it drives a stall that freezes the upstream pipeline until the access completes.
- It replaces ad-hoc per-element address/input/output managers with one sequencer.

Parameters:
- LANES, 16, number of elements in a vector access.
- EW, 16, element width in bits.
- AW, 19, RAM address width.
- RD_LAT, 1, RAM read latency in clk cycles, from address to q (1..4).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  EX/MEM holds a memory instruction
- req_write  in  1  1 = store, 0 = load
- req_vector  in  1  1 = vector (LANES elements), 0 = scalar (1 element)
- req_addr  in  AW  base address (ALU result)
- req_wdata_s  in  EW  scalar store data
- req_wdata_v  in  LANES*EW  vector store data; lane i = bits [i*EW +: EW]
- req_rd  in  5  destination register of a load
- ram_addr  out  AW  RAM address
- ram_wdata  out  EW  RAM write data
- ram_wren  out  1  RAM write enable
- ram_q  in  EW  RAM read data
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- done  out  1  one-cycle pulse; access complete
- rd_vector  out  LANES*EW  gathered load data
- rd_scalar  out  AW  lane 0 of rd_vector, zero-extended
- rd_dest  out  5  captured req_rd
- busy_cycles  out  AW  saturating count of cycles spent in ISSUE or DRAIN

Behaviour:
- States: IDLE, ISSUE, DRAIN, DONE.
- Reset values: state=IDLE, idx=0, ram_wren=0, ram_addr=0, ram_wdata=0, done=0, rd_vector=0, rd_dest=0, busy_cycles=0; in-flight read tags are cleared.
- IDLE:
  - On req_valid, capture op, base, write data and rd.
  - Load count = LANES for a vector access, 1 for scalar.
  - Clear rd_vector, set idx=0, go to ISSUE.
- ISSUE, one element per cycle:
  - ram_addr = (base + idx) mod 2^AW; the address wraps, no error.
  - Store: ram_wren=1, ram_wdata = lane idx for vector, scalar data for scalar.
  - Load: ram_wren=0; push tag idx into an RD_LAT-deep delay line.
  - idx increments each cycle.
  - After the element count-1 is issued: store goes to DONE; load goes to DRAIN.
- DRAIN: holds for exactly RD_LAT cycles, then goes to DONE.
- Load capture: whenever a valid tag exits the delay line, write ram_q into lane tag. This happens in ISSUE and DRAIN alike.
- DONE:
  - done=1 for exactly one cycle; next state is IDLE.
  - req_valid is ignored in DONE, since it still reflects the completed instruction.
- stall (combinational) = (state==IDLE && req_valid) || state==ISSUE || state==DRAIN. stall is 0 in DONE so the pipeline advances.
- Outputs outside ISSUE: ram_wren=0; ram_addr holds its last value.
- rd_vector, rd_scalar and rd_dest hold their values from DONE until the next accept.
- Latency, measured from accept cycle T:
  - vector store: done at T+LANES+1
  - vector load: done at T+LANES+RD_LAT+1
  - scalar store: done at T+2
  - scalar load: done at T+2+RD_LAT
- Store data lanes change only in ISSUE, never mid-element.
- rst asserted mid-access: the access is aborted the next cycle. No further RAM writes, no done pulse, stall drops.
- busy_cycles increments in ISSUE and DRAIN and saturates at 2^AW-1.

Test Plan:
- Vector store, base=0x100, lane i=0x1000+i, RD_LAT=1 -> ram_wren high for 16 cycles at 0x100..0x10F with data 0x1000..0x100F; done at T+17; stall high T..T+16.
- Vector load from a RAM model holding mem[a]=a[15:0], base=0x200, req_rd=7 -> done at T+18; lane i=0x200+i; rd_dest=7; stall low in the done cycle.
- Scalar load at 0x7FFFF with mem=0xBEEF, RD_LAT=2 -> one RAM access; done at T+4; rd_scalar=0x0BEEF; lanes 1..15 = 0.
- Vector store, base=0x7FFF8 -> addresses 0x7FFF8..0x7FFFF, then 0x00000..0x00007 (wrap).
- rst asserted at idx=5 of a vector store -> exactly 5 writes observed, state IDLE, stall=0, done never pulses; a following scalar store completes normally.
- Back-to-back: req_valid held through DONE, then a new request -> the first request is not re-issued; the second is accepted in the IDLE cycle after DONE.

Source files
------------

// File: rtl/vec_mem_sequencer.sv
// rtl/vec_mem_sequencer.sv - MEM-stage sequencer turning scalar/vector load/store into per-element RAM accesses
//
// Purpose:
//   Accepts one memory instruction from EX/MEM and issues it to a single-port
//   data RAM as one (scalar) or LANES (vector) consecutive element accesses.
//   Load data returning after RD_LAT cycles is gathered into a LANES-wide
//   vector. The upstream pipeline is stalled until the access completes.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid                EX/MEM holds a memory instruction
//   req_write                1 = store, 0 = load
//   req_vector               1 = vector (LANES elements), 0 = scalar
//   req_addr                 base address
//   req_wdata_s              scalar store data
//   req_wdata_v              vector store data, lane i = [i*EW +: EW]
//   req_rd                   load destination register
//   ram_addr/wdata/wren      RAM request (registered)
//   ram_q                    RAM read data, RD_LAT cycles after address
//   stall                    freeze upstream pipeline
//   done                     one-cycle completion pulse
//   rd_vector                gathered load data
//   rd_scalar                lane 0 of rd_vector, zero-extended to AW
//   rd_dest                  captured req_rd
//   busy_cycles              saturating count of ISSUE/DRAIN cycles

module vec_mem_sequencer #(
    parameter int LANES  = 16,
    parameter int EW     = 16,
    parameter int AW     = 19,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic                  req_vector,
    input  logic [AW-1:0]         req_addr,
    input  logic [EW-1:0]         req_wdata_s,
    input  logic [LANES*EW-1:0]   req_wdata_v,
    input  logic [4:0]            req_rd,
    output logic [AW-1:0]         ram_addr,
    output logic [EW-1:0]         ram_wdata,
    output logic                  ram_wren,
    input  logic [EW-1:0]         ram_q,
    output logic                  stall,
    output logic                  done,
    output logic [LANES*EW-1:0]   rd_vector,
    output logic [AW-1:0]         rd_scalar,
    output logic [4:0]            rd_dest,
    output logic [AW-1:0]         busy_cycles
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q;

    // Captured request
    logic                  write_q;
    logic                  vector_q;
    logic [AW-1:0]         base_q;
    logic [EW-1:0]         wdata_s_q;
    logic [LANES*EW-1:0]   wdata_v_q;
    logic [LW-1:0]         idx_q;
    logic [LW-1:0]         last_idx_q;
    logic [2:0]            drain_cnt_q;

    // Read-tag delay line: stage RD_LAT-1 lines up with ram_q for the
    // element whose address was on the bus RD_LAT cycles earlier.
    logic [RD_LAT-1:0]     tag_v_q;
    logic [LW-1:0]         tag_idx_q [RD_LAT];

    // Registered outputs
    logic [AW-1:0]         ram_addr_q;
    logic [EW-1:0]         ram_wdata_q;
    logic                  ram_wren_q;
    logic                  done_q;
    logic [LANES*EW-1:0]   rd_vector_q;
    logic [4:0]            rd_dest_q;
    logic [AW-1:0]         busy_q;

    // Next-element values, used while stepping through ISSUE
    logic [LW-1:0]         idx_d;
    logic [AW-1:0]         addr_d;
    logic [EW-1:0]         wdata_d;
    logic [AW-1:0]         busy_d;
    logic                  is_last;

    always_comb begin
        idx_d   = idx_q + LW'(1);
        // Address arithmetic is modulo 2^AW, so a vector may wrap past the top.
        addr_d  = base_q + AW'(idx_d);
        wdata_d = vector_q ? wdata_v_q[idx_d*EW +: EW] : wdata_s_q;
        busy_d  = (busy_q == {AW{1'b1}}) ? busy_q : busy_q + AW'(1);
        is_last = (idx_q == last_idx_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            write_q     <= 1'b0;
            vector_q    <= 1'b0;
            base_q      <= '0;
            wdata_s_q   <= '0;
            wdata_v_q   <= '0;
            idx_q       <= '0;
            last_idx_q  <= '0;
            drain_cnt_q <= '0;
            tag_v_q     <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_idx_q[i] <= '0;
            end
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_wren_q  <= 1'b0;
            done_q      <= 1'b0;
            rd_vector_q <= '0;
            rd_dest_q   <= '0;
            busy_q      <= '0;
        end else begin
            done_q <= 1'b0;

            // Tag pipeline advances every cycle; only load issues push valid tags.
            tag_v_q[0]   <= (state_q == S_ISSUE) && !write_q;
            tag_idx_q[0] <= idx_q;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v_q[i]   <= tag_v_q[i-1];
                tag_idx_q[i] <= tag_idx_q[i-1];
            end

            if (state_q == S_ISSUE || state_q == S_DRAIN) begin
                busy_q <= busy_d;
            end

            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        write_q     <= req_write;
                        vector_q    <= req_vector;
                        base_q      <= req_addr;
                        wdata_s_q   <= req_wdata_s;
                        wdata_v_q   <= req_wdata_v;
                        rd_dest_q   <= req_rd;
                        idx_q       <= '0;
                        last_idx_q  <= req_vector ? LW'(LANES - 1) : '0;
                        rd_vector_q <= '0;
                        // Element 0 is presented on the RAM bus in the first ISSUE cycle.
                        ram_addr_q  <= req_addr;
                        ram_wren_q  <= req_write;
                        if (req_write) begin
                            ram_wdata_q <= req_vector ? req_wdata_v[EW-1:0] : req_wdata_s;
                        end
                        state_q     <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (is_last) begin
                        ram_wren_q  <= 1'b0;
                        drain_cnt_q <= '0;
                        if (write_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_DRAIN;
                        end
                    end else begin
                        idx_q      <= idx_d;
                        ram_addr_q <= addr_d;
                        if (write_q) begin
                            ram_wdata_q <= wdata_d;
                        end
                    end
                end

                S_DRAIN: begin
                    // Holds RD_LAT cycles so the last element's data is captured.
                    if (drain_cnt_q == 3'(RD_LAT - 1)) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 3'd1;
                    end
                end

                S_DONE: begin
                    // req_valid still shows the finished instruction here; ignore it.
                    state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase

            if (tag_v_q[RD_LAT-1]) begin
                rd_vector_q[tag_idx_q[RD_LAT-1]*EW +: EW] <= ram_q;
            end
        end
    end

    assign stall       = ((state_q == S_IDLE) && req_valid) ||
                         (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign ram_wren    = ram_wren_q;
    assign done        = done_q;
    assign rd_vector   = rd_vector_q;
    assign rd_scalar   = AW'(rd_vector_q[EW-1:0]);
    assign rd_dest     = rd_dest_q;
    assign busy_cycles = busy_q;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// tb/tb_vec_mem_sequencer.sv - directed self-checking bench for vec_mem_sequencer
module tb_vec_mem_sequencer;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_write, req_vector;
    logic [18:0]   req_addr;
    logic [15:0]   req_wdata_s;
    logic [255:0]  req_wdata_v;
    logic [4:0]    req_rd;

    // Instance 1: RD_LAT=1
    logic          valid1, wren1, stall1, done1;
    logic [18:0]   addr1, rd_scalar1, busy1;
    logic [15:0]   wdata1, q1;
    logic [255:0]  rd_vector1;
    logic [4:0]    rd_dest1;

    // Instance 2: RD_LAT=2
    logic          valid2, wren2, stall2, done2;
    logic [18:0]   addr2, rd_scalar2, busy2;
    logic [15:0]   wdata2, q2, q2a;
    logic [255:0]  rd_vector2;
    logic [4:0]    rd_dest2;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic          sel;
    logic          s_done, s_stall, s_wren;
    logic [18:0]   s_addr;
    logic [15:0]   s_wdata;
    logic [18:0]   wa [$];
    logic [15:0]   wd [$];
    bit            stall_drop;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vec_mem_sequencer #(.LANES(16), .EW(16), .AW(19), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(valid1), .req_write(req_write),
        .req_vector(req_vector), .req_addr(req_addr), .req_wdata_s(req_wdata_s),
        .req_wdata_v(req_wdata_v), .req_rd(req_rd), .ram_addr(addr1),
        .ram_wdata(wdata1), .ram_wren(wren1), .ram_q(q1), .stall(stall1),
        .done(done1), .rd_vector(rd_vector1), .rd_scalar(rd_scalar1),
        .rd_dest(rd_dest1), .busy_cycles(busy1)
    );

    vec_mem_sequencer #(.LANES(16), .EW(16), .AW(19), .RD_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(valid2), .req_write(req_write),
        .req_vector(req_vector), .req_addr(req_addr), .req_wdata_s(req_wdata_s),
        .req_wdata_v(req_wdata_v), .req_rd(req_rd), .ram_addr(addr2),
        .ram_wdata(wdata2), .ram_wren(wren2), .ram_q(q2), .stall(stall2),
        .done(done2), .rd_vector(rd_vector2), .rd_scalar(rd_scalar2),
        .rd_dest(rd_dest2), .busy_cycles(busy2)
    );

    // RAM models: mem[a] = a[15:0]; instance 2 holds 0xBEEF at 0x7FFFF.
    always @(posedge clk) q1 <= addr1[15:0];
    always @(posedge clk) begin
        q2a <= (addr2 == 19'h7FFFF) ? 16'hBEEF : addr2[15:0];
        q2  <= q2a;
    end

    assign s_done  = sel ? done2  : done1;
    assign s_stall = sel ? stall2 : stall1;
    assign s_wren  = sel ? wren2  : wren1;
    assign s_addr  = sel ? addr2  : addr1;
    assign s_wdata = sel ? wdata2 : wdata1;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge of the accept cycle; returns cycles until done (-1 on timeout).
    task automatic run_until_done(input int budget, output int lat);
        lat = -1;
        wa.delete();
        wd.delete();
        stall_drop = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (s_done) begin
                lat = k;
                break;
            end
            if (!s_stall) stall_drop = 1'b1;
            if (s_wren) begin
                wa.push_back(s_addr);
                wd.push_back(s_wdata);
            end
        end
    endtask

    initial begin
        int          lat;
        int          nwr;
        bit          ok;
        bit          saw_done;
        logic [255:0] exp_v;

        rst = 1'b1; valid1 = 1'b0; valid2 = 1'b0; sel = 1'b0;
        req_write = 1'b0; req_vector = 1'b0; req_addr = '0;
        req_wdata_s = '0; req_wdata_v = '0; req_rd = '0;
        repeat (3) @(negedge clk);
        check("rst_done",   256'(done1),      256'(0));
        check("rst_wren",   256'(wren1),      256'(0));
        check("rst_addr",   256'(addr1),      256'(0));
        check("rst_wdata",  256'(wdata1),     256'(0));
        check("rst_rdvec",  256'(rd_vector1), 256'(0));
        check("rst_rddest", 256'(rd_dest1),   256'(0));
        check("rst_busy",   256'(busy1),      256'(0));
        check("rst_stall",  256'(stall1),     256'(0));
        rst = 1'b0;

        // Vector store, base 0x100, lane i = 0x1000+i
        @(negedge clk);
        req_write = 1'b1; req_vector = 1'b1; req_addr = 19'h100;
        for (int i = 0; i < 16; i++) req_wdata_v[i*16 +: 16] = 16'(32'h1000 + i);
        valid1 = 1'b1;
        #1 check("vst_stall_accept", 256'(stall1), 256'(1));
        run_until_done(40, lat);
        check("vst_latency", 256'(lat), 256'(17));
        check("vst_stall_held", 256'(stall_drop), 256'(0));
        check("vst_stall_done", 256'(stall1), 256'(0));
        ok = (wa.size() == 16);
        for (int i = 0; i < wa.size(); i++)
            if (wa[i] !== 19'(32'h100 + i) || wd[i] !== 16'(32'h1000 + i)) ok = 1'b0;
        check("vst_writes", 256'(ok), 256'(1));
        check("vst_busy", 256'(busy1), 256'(16));
        valid1 = 1'b0;

        // Vector load, base 0x200, rd 7
        @(negedge clk);
        req_write = 1'b0; req_vector = 1'b1; req_addr = 19'h200; req_rd = 5'd7;
        valid1 = 1'b1;
        run_until_done(40, lat);
        for (int i = 0; i < 16; i++) exp_v[i*16 +: 16] = 16'(32'h200 + i);
        check("vld_latency", 256'(lat), 256'(18));
        check("vld_stall_done", 256'(stall1), 256'(0));
        check("vld_no_writes", 256'(wa.size()), 256'(0));
        check("vld_data", rd_vector1, exp_v);
        check("vld_rddest", 256'(rd_dest1), 256'(7));
        valid1 = 1'b0;
        @(negedge clk);
        check("vld_hold", rd_vector1, exp_v);
        check("vld_busy", 256'(busy1), 256'(33));

        // Scalar load at 0x7FFFF on the RD_LAT=2 instance
        sel = 1'b1;
        req_write = 1'b0; req_vector = 1'b0; req_addr = 19'h7FFFF; req_rd = 5'd3;
        valid2 = 1'b1;
        run_until_done(20, lat);
        check("sld_latency", 256'(lat), 256'(4));
        check("sld_rdscalar", 256'(rd_scalar2), 256'(19'h0BEEF));
        check("sld_rdvector", rd_vector2, 256'(16'hBEEF));
        check("sld_rddest", 256'(rd_dest2), 256'(3));
        check("sld_busy", 256'(busy2), 256'(3));
        valid2 = 1'b0;
        sel = 1'b0;
        @(negedge clk);

        // Vector store wrapping past the top of the address space
        req_write = 1'b1; req_vector = 1'b1; req_addr = 19'h7FFF8;
        for (int i = 0; i < 16; i++) req_wdata_v[i*16 +: 16] = 16'(32'hA000 + i);
        valid1 = 1'b1;
        run_until_done(40, lat);
        check("wrap_latency", 256'(lat), 256'(17));
        ok = (wa.size() == 16);
        for (int i = 0; i < wa.size(); i++)
            if (wa[i] !== 19'((32'h7FFF8 + i) & 32'h7FFFF) || wd[i] !== 16'(32'hA000 + i)) ok = 1'b0;
        check("wrap_writes", 256'(ok), 256'(1));
        valid1 = 1'b0;
        @(negedge clk);

        // Reset after five elements of a vector store
        req_write = 1'b1; req_vector = 1'b1; req_addr = 19'h300;
        for (int i = 0; i < 16; i++) req_wdata_v[i*16 +: 16] = 16'(32'hC000 + i);
        valid1 = 1'b1;
        nwr = 0;
        saw_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (wren1) nwr++;
            if (nwr == 5) break;
        end
        rst = 1'b1;
        valid1 = 1'b0;
        @(negedge clk);
        check("abort_wren", 256'(wren1), 256'(0));
        check("abort_stall", 256'(stall1), 256'(0));
        check("abort_busy", 256'(busy1), 256'(0));
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (wren1) nwr++;
            if (done1) saw_done = 1'b1;
        end
        check("abort_writes", 256'(nwr), 256'(5));
        check("abort_no_done", 256'(saw_done), 256'(0));

        req_write = 1'b1; req_vector = 1'b0; req_addr = 19'h400; req_wdata_s = 16'h5A5A;
        valid1 = 1'b1;
        run_until_done(20, lat);
        check("post_abort_latency", 256'(lat), 256'(2));
        ok = (wa.size() == 1) && (wa[0] === 19'h400) && (wd[0] === 16'h5A5A);
        check("post_abort_write", 256'(ok), 256'(1));
        valid1 = 1'b0;
        @(negedge clk);

        // Back-to-back: first request held through DONE, then a new one
        req_write = 1'b1; req_vector = 1'b0; req_addr = 19'h500; req_wdata_s = 16'h1111;
        valid1 = 1'b1;
        run_until_done(20, lat);
        check("b2b_first_latency", 256'(lat), 256'(2));
        ok = (wa.size() == 1) && (wa[0] === 19'h500) && (wd[0] === 16'h1111);
        check("b2b_first_write", 256'(ok), 256'(1));
        req_addr = 19'h501; req_wdata_s = 16'h2222;
        run_until_done(20, lat);
        check("b2b_second_latency", 256'(lat), 256'(3));
        ok = (wa.size() == 1) && (wa[0] === 19'h501) && (wd[0] === 16'h2222);
        check("b2b_second_write", 256'(ok), 256'(1));
        valid1 = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
